// File: rtl/countryroad_ctrl_if.sv
// Link between the highway controller and the country-road controller.
//
// Signal semantics (no valid/ready pairs; all signals are level or pulse):
//   enable_countryroad : level, highway -> country. 1 while the country road
//                        may show green; must stay 0 through country yellow.
//   mode               : level, highway -> country. Selects the interval
//                        length: 0 = long hold period, 1 = short yellow period.
//   timeout            : single-cycle pulse, country -> highway. Marks the end
//                        of the current interval; sampled by both sides at the
//                        next rising clock edge.
//   countryroad_led    : one-hot country light (100 green, 010 yellow, 001 red).
//   fault              : sticky protocol-violation flag, cleared only by reset.
//   state_dbg          : country FSM state, for observation only.
interface countryroad_ctrl_if;
    logic       enable_countryroad;
    logic       mode;
    logic       timeout;
    logic [2:0] countryroad_led;
    logic       fault;
    logic [1:0] state_dbg;

    modport master (
        output enable_countryroad,
        output mode,
        input  timeout,
        input  countryroad_led,
        input  fault,
        input  state_dbg
    );

    modport slave (
        input  enable_countryroad,
        input  mode,
        output timeout,
        output countryroad_led,
        output fault,
        output state_dbg
    );
endinterface

// File: rtl/countryroad_ctrl.sv
// Country-road light controller: interval timer producing the highway's
// timeout pulse, plus the country light FSM following the hand-over protocol.
module countryroad_ctrl #(
    parameter int T_LONG  = 10,
    parameter int T_SHORT = 3,
    parameter int CNT_W   = 8
) (
    input logic              clk,
    input logic              rst_n,
    countryroad_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RED    = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2
    } state_t;

    // Last count value of each interval; the counter restarts after it.
    localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(T_LONG - 1);
    localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(T_SHORT - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last;
    logic             expired;

    state_t           state;
    state_t           state_nxt;
    logic             fault_q;
    logic             fault_nxt;
    logic [2:0]       led;

    // Interval end is compared with >= so that shortening the interval
    // mid-count fires immediately instead of running to the wrap.
    always_comb begin
        last    = bus.mode ? SHORT_LAST : LONG_LAST;
        expired = (cnt >= last);
    end

    // Timeout is held low while reset is asserted, whatever the mode.
    assign bus.timeout = expired & rst_n;

    // Interval counter: restart on expiry, otherwise count up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (expired) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // State and sticky fault registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RED;
            fault_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            fault_q <= fault_nxt;
        end
    end

    // Next-state logic and Moore light decode.
    always_comb begin
        state_nxt = state;
        fault_nxt = fault_q;
        led       = 3'b001;
        unique case (state)
            ST_RED: begin
                led = 3'b001;
                if (bus.enable_countryroad) begin
                    state_nxt = ST_GREEN;
                end
            end
            ST_GREEN: begin
                led = 3'b100;
                if (!bus.enable_countryroad) begin
                    state_nxt = ST_YELLOW;
                end
            end
            ST_YELLOW: begin
                led = 3'b010;
                // Enable during our yellow is a highway violation; it takes
                // priority over a coincident timeout.
                if (bus.enable_countryroad) begin
                    state_nxt = ST_RED;
                    fault_nxt = 1'b1;
                end else if (expired) begin
                    state_nxt = ST_RED;
                end
            end
            default: begin
                led       = 3'b001;
                state_nxt = ST_RED;
            end
        endcase
    end

    assign bus.countryroad_led = led;
    assign bus.fault           = fault_q;
    assign bus.state_dbg       = state;

endmodule

// File: doc/countryroad_ctrl.md
Name: countryroad_ctrl

Overview:
- Companion to the highway light controller. Receives that controller's enable_countryroad and mode outputs and returns its timeout input.
- Two functions:
  - Interval timer that generates the timeout pulse: long period T while mode=0, short period t while mode=1.
  - Country-road light FSM that follows the highway's hand-over protocol.
- Also flags protocol violations.
- Sits beside the highway controller in the traffic_lights top level.

Parameters:
- T_LONG, 10, green/red hold period in clk cycles (mode=0); 2 <= T_LONG < 2^CNT_W
- T_SHORT, 3, yellow period in clk cycles (mode=1); 1 <= T_SHORT <= T_LONG
- CNT_W, 8, interval counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- enable_countryroad  in  1  from highway controller; 1 = country road may be green
- mode  in  1  from highway controller; 0 = long period T, 1 = short period t
- timeout  out  1  to highway controller; one-cycle interval-expired pulse
- countryroad_led  out  3  one-hot: 100 green, 010 yellow, 001 red
- fault  out  1  sticky protocol-violation flag

Behaviour:
- Reset (async, rst_n=0):
  - cnt=0, FSM=RED.
  - countryroad_led=001, timeout=0, fault=0, immediately without waiting for a clock edge.
- Interval timer:
  - TARGET = mode ? T_SHORT : T_LONG, evaluated from the current mode every cycle.
  - timeout = (cnt >= TARGET-1), combinational from cnt and mode. Use >=, not ==, so a mid-count switch to the short target can never miss.
  - Each posedge: cnt <= 0 if timeout=1, else cnt <= cnt+1.
  - Consequence: consecutive timeouts at constant mode are exactly TARGET cycles apart. The first timeout after reset release occurs in cycle TARGET-1, counting from 0.
  - A mode change without a timeout does not restart the count. If cnt already >= new TARGET-1, timeout asserts in that same cycle.
  - cnt never wraps, because the >= compare restarts it first.
- Country FSM: Moore outputs decoded from state only; state registered; transitions at posedge.
  - RED (led 001): enable_countryroad=1 -> GREEN; else stay.
  - GREEN (led 100): enable_countryroad=0 -> YELLOW; else stay.
  - YELLOW (led 010):
    - enable_countryroad=1 -> RED and fault<=1 (violation; highway must hold enable low through the country yellow).
    - else timeout=1 -> RED (same pulse that moves the highway from red-hold back to green).
    - else stay.
  - If enable and timeout are both 1 in YELLOW, the violation wins: RED with fault set.
- Latency:
  - country green appears 1 cycle after enable_countryroad rises;
  - yellow 1 cycle after it falls;
  - red 1 cycle after the terminating timeout.
  - The highway is already red (001) while enable=1, so that 1-cycle lag never overlaps green/yellow phases.
- fault: set as above; cleared only by rst_n.
- sensor is not an input. A highway green with sensor=0 simply consumes the timeout; the timer restarts regardless.
- Reset mid-operation, any state: immediate return to the reset values listed above.

Test Plan:
- Reset, then release with mode=0, enable=0 -> led=001, fault=0; timeout high only in cycle 9 after release, then again in cycles 19, 29.
- Closed loop with highway controller, sensor=1 held:
  - highway 100 for 10 cycles, then 010 for 3;
  - country goes 001 -> 100 one cycle after highway enters red and stays 100 for 10 cycles;
  - country 010 for 3 cycles, then 001 with highway back to 100;
  - at no cycle is the highway led != 001 while the country led != 001.
- Closed loop, sensor=0 -> timeout every 10 cycles, highway stays 100, country stays 001, fault=0.
- Mode switch 0->1 at cnt=5 with no timeout that cycle -> timeout=1 in that same cycle, cnt=0 next cycle, next timeout 3 cycles later.
- Drive GREEN via enable=1, drop enable to 0 (-> YELLOW), raise enable to 1 in the next cycle -> led=001 and fault=1 the following cycle; fault stays 1 until rst_n pulses low.
- Assert rst_n=0 asynchronously mid-GREEN with cnt=6 -> led=001, timeout=0, cnt=0 before the next clk edge; normal sequence resumes after release.
